stage_to_buffer_bb: RTL and testbench

//  Drains a completed FFT stage memory into a downstream buffer_BB FIFO, inverse of buffer_BB_to_stage.

---
 rtl/stage_to_buffer_bb_pkg.sv | 15 +
 rtl/stage_to_buffer_bb_if.sv | 24 ++
 rtl/stage_to_buffer_bb_bit_reverse.sv | 11 +
 rtl/stage_to_buffer_bb.sv | 154 +++++++++++++++
 tb/tb_stage_to_buffer_bb.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/stage_to_buffer_bb_pkg.sv
// Shared types for the stage-memory to buffer_BB drain block.
package stage_to_buffer_bb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Frame counters need one extra bit so that N itself is representable.
    function automatic int cnt_width(input int log_n);
        return log_n + 1;
    endfunction

endpackage

// File: rtl/stage_to_buffer_bb_if.sv
// Stage-memory read port plus FIFO write port, grouped as one bus.
interface stage_to_buffer_bb_if #(
    parameter int LOG_N  = 3,
    parameter int WIDTH  = 32,
    parameter int MWIDTH = 1
);
    logic [LOG_N-1:0]        addr;
    logic [WIDTH-1:0]        in_data;
    logic                    out_mread;
    logic [MWIDTH-1:0]       in_m;
    logic                    write_full;
    logic                    write_strobe;
    logic [WIDTH+MWIDTH-1:0] write_data;

    modport master (
        output addr, out_mread, write_strobe, write_data,
        input  in_data, in_m, write_full
    );

    modport slave (
        input  addr, out_mread, write_strobe, write_data,
        output in_data, in_m, write_full
    );
endinterface

// File: rtl/stage_to_buffer_bb_bit_reverse.sv
// Combinational bit reversal of a read index.
module stage_to_buffer_bb_bit_reverse #(
    parameter int W = 3
) (
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign out_o[i] = in_i[W-1-i];
    end
endmodule

// File: rtl/stage_to_buffer_bb.sv
// Drains one FFT stage memory frame into a buffer_BB FIFO, honouring write_full
// through a single-entry hold register.
module stage_to_buffer_bb
    import stage_to_buffer_bb_pkg::*;
#(
    parameter int N      = 8,
    parameter int LOG_N  = 3,
    parameter int WIDTH  = 32,
    parameter int MWIDTH = 1,
    parameter int BITREV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    stage_to_buffer_bb_if.master  bus,
    output logic                  active_o,
    output logic                  finished_o,
    output logic                  error_o
);
    localparam int              CW  = cnt_width(LOG_N);
    localparam logic [CW-1:0]   N_C = CW'(N);

    state_e                  state_q, state_d;
    logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]           wr_cnt_q, wr_cnt_d;
    logic [LOG_N-1:0]        addr_q;
    logic [LOG_N-1:0]        rd_lin, rd_addr;
    logic                    ret_vld_q;
    logic                    hold_vld_q, hold_vld_d;
    logic [WIDTH+MWIDTH-1:0] hold_q, hold_d;
    logic                    error_q, error_d;
    logic                    issue;
    logic                    push;

    assign rd_lin = rd_cnt_q[LOG_N-1:0];

    if (BITREV != 0) begin : g_bitrev
        stage_to_buffer_bb_bit_reverse #(.W(LOG_N)) u_bitrev (
            .in_i  (rd_lin),
            .out_o (rd_addr)
        );
    end else begin : g_linear
        assign rd_addr = rd_lin;
    end

    always_comb begin
        state_d          = state_q;
        rd_cnt_d         = rd_cnt_q;
        wr_cnt_d         = wr_cnt_q;
        hold_vld_d       = hold_vld_q;
        hold_d           = hold_q;
        error_d          = error_q;
        issue            = 1'b0;
        push             = 1'b0;
        bus.addr         = addr_q;
        bus.out_mread    = 1'b0;
        bus.write_strobe = 1'b0;
        bus.write_data   = '0;
        active_o         = 1'b0;
        finished_o       = 1'b0;

        if (hold_vld_q && !bus.write_full) begin
            push             = 1'b1;
            bus.write_strobe = 1'b1;
            bus.write_data   = hold_q;
            hold_vld_d       = 1'b0;
        end

        if (ret_vld_q) begin
            if (!bus.write_full) begin
                push             = 1'b1;
                bus.write_strobe = 1'b1;
                bus.write_data   = {bus.in_data, bus.in_m};
            end else begin
                hold_vld_d = 1'b1;
                hold_d     = {bus.in_data, bus.in_m};
            end
        end

        if (hold_vld_q && ret_vld_q && bus.write_full) begin
            error_d = 1'b1;
        end

        if (push) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end
            end
            ST_RUN: begin
                active_o = 1'b1;
                if (start_i) begin
                    error_d = 1'b1;
                end
                // A valid hold always drains when write_full is low, so it never blocks issue here.
                issue = (rd_cnt_q < N_C) && !bus.write_full;
                if (issue) begin
                    bus.addr      = rd_addr;
                    bus.out_mread = 1'b1;
                    rd_cnt_d      = rd_cnt_q + CW'(1);
                end
                if (push && (wr_cnt_q == N_C - CW'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                finished_o = 1'b1;
                if (start_i) begin
                    state_d  = ST_RUN;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            addr_q     <= '0;
            ret_vld_q  <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            addr_q     <= bus.addr;
            ret_vld_q  <= issue;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
            error_q    <= error_d;
        end
    end

    assign error_o = error_q;

    // Issue is gated by write_full, so a return can never land on a full hold.
    a_no_hold_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(hold_vld_q && ret_vld_q && bus.write_full));

endmodule

// File: tb/tb_stage_to_buffer_bb.sv
// Scoreboard bench: one bit-reversed and one linear instance driven in lock-step.
module tb_stage_to_buffer_bb;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic full = 1'b0;
    logic act [2];
    logic fin [2];
    logic err [2];

    int n_tests = 0;
    int n_fail  = 0;
    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        stage_to_buffer_bb_if #(.LOG_N(3), .WIDTH(32), .MWIDTH(1)) bus ();
        logic [32:0] wq [$];
        logic [2:0]  aq [$];
        int          nwr = 0;
        logic [31:0] pop_cnt;

        stage_to_buffer_bb #(
            .N(N), .LOG_N(3), .WIDTH(32), .MWIDTH(1), .BITREV(g == 0 ? 1 : 0)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start_i    (start),
            .bus        (bus),
            .active_o   (act[g]),
            .finished_o (fin[g]),
            .error_o    (err[g])
        );

        assign bus.write_full = full;

        // Stage memory holds 100+i; mstore yields the parity of its pop index.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pop_cnt     <= 0;
                bus.in_data <= '0;
                bus.in_m    <= '0;
            end else begin
                bus.in_data <= 32'd100 + 32'(bus.addr);
                if (bus.out_mread) begin
                    bus.in_m <= pop_cnt[0];
                    pop_cnt  <= pop_cnt + 1;
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                if (bus.write_strobe) begin
                    chk($sformatf("full_at_wr%0d", g), 64'(bus.write_full), 64'd0);
                    chk($sformatf("wr_pending%0d", g), 64'(wq.size() != 0), 64'd1);
                    if (wq.size() != 0) chk($sformatf("wdata%0d", g), 64'(bus.write_data), 64'(wq.pop_front()));
                    nwr++;
                end
                if (bus.out_mread) begin
                    chk($sformatf("rd_pending%0d", g), 64'(aq.size() != 0), 64'd1);
                    if (aq.size() != 0) chk($sformatf("addr%0d", g), 64'(bus.addr), 64'(aq.pop_front()));
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  64'(gen_dut[0].bus.addr), 64'd0);
        chk({tag, "_mread"}, 64'(gen_dut[0].bus.out_mread), 64'd0);
        chk({tag, "_strobe"}, 64'(gen_dut[0].bus.write_strobe), 64'd0);
        chk({tag, "_wdata"}, 64'(gen_dut[0].bus.write_data), 64'd0);
        chk({tag, "_active"}, 64'(act[0]), 64'd0);
        chk({tag, "_fin"},   64'(fin[0]), 64'd0);
        chk({tag, "_err"},   64'(err[0]), 64'd0);
    endtask

    // mode: 0 no backpressure, 1 full burst j=4..6, 2 full on odd cycles, 3 second start at j=4
    task automatic run_frame(input string tag, input int mode, input int exp_first,
                             input int exp_fin, input int cut_at);
        int   first = -1;
        bit   done  = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        full  = 1'b0;
        gen_dut[0].nwr = 0;
        gen_dut[1].nwr = 0;
        for (int k = 0; k < N; k++) begin
            gen_dut[0].wq.push_back({32'(100 + br[k]), k[0]});
            gen_dut[1].wq.push_back({32'(100 + k), k[0]});
            gen_dut[0].aq.push_back(3'(br[k]));
            gen_dut[1].aq.push_back(3'(k));
        end
        for (int j = 1; j < 60 && !done; j++) begin
            @(posedge clk); #1;
            start = (mode == 3 && j == 4);
            full  = (mode == 1 && j >= 4 && j <= 6) || (mode == 2 && j[0]);
            if (cut_at == j) begin
                rst_n = 1'b0;
                @(negedge clk);
                return;
            end
            @(negedge clk);
            if (first < 0 && gen_dut[0].bus.write_strobe) first = j;
            if (fin[0]) begin
                done = 1'b1;
                chk({tag, "_fin_cyc"}, 64'(j), 64'(exp_fin));
                chk({tag, "_fin_lin"}, 64'(fin[1]), 64'd1);
            end
        end
        full = 1'b0;
        chk({tag, "_no_timeout"}, 64'(done), 64'd1);
        chk({tag, "_first_wr"}, 64'(first), 64'(exp_first));
        chk({tag, "_nwr0"}, 64'(gen_dut[0].nwr), 64'd8);
        chk({tag, "_nwr1"}, 64'(gen_dut[1].nwr), 64'd8);
        chk({tag, "_q_left"}, 64'(gen_dut[0].wq.size() + gen_dut[1].wq.size()), 64'd0);
        @(negedge clk);
        chk({tag, "_fin_pulse"}, 64'(fin[0]), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("idle");

        run_frame("t1_plain", 0, 2, 10, 0);
        chk("t1_err", 64'(err[0]), 64'd0);
        run_frame("t2_burst", 1, 2, 13, 0);
        chk("t2_err", 64'(err[0]), 64'd0);
        run_frame("t3_toggle", 2, 4, 19, 0);
        chk("t3_err", 64'(err[0] | err[1]), 64'd0);
        run_frame("t4_restart", 3, 2, 10, 0);
        chk("t4_err0", 64'(err[0]), 64'd1);
        chk("t4_err1", 64'(err[1]), 64'd1);

        run_frame("t5_cut", 0, 2, 10, 6);
        chk("t5_nwr_before_cut", 64'(gen_dut[0].nwr), 64'd4);
        chk_reset_vals("t5_rst");
        for (int g = 0; g < 2; g++) begin
            if (g == 0) begin gen_dut[0].wq.delete(); gen_dut[0].aq.delete(); end
            else        begin gen_dut[1].wq.delete(); gen_dut[1].aq.delete(); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_fin", 64'(fin[0]), 64'd0);
        end
        run_frame("t5_after", 0, 2, 10, 0);
        chk("t5_err_clear", 64'(err[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
